imem_loader: RTL and testbench

//   Write side of the byte-wide little-endian instruction memory that the fetch stage reads.
//   - Accepts 32-bit instruction words over a valid/ready stream.
//   - Writes each word as 4 byte beats (LSB first) to an auto-incrementing address.
//   - Holds the CPU while loading; stops on the halt word (beq x0,x0,0) or on overflow.

---
 rtl/imem_loader.sv | 105 ++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Write side of the byte-wide instruction memory: takes 32-bit words over valid/ready
// and writes them LSB-first as four byte beats to an auto-incrementing address.
module imem_loader #(
    parameter int          ADDR_W    = 7,
    parameter int          MEM_BYTES = 128,
    parameter logic [31:0] HALT_WORD = 32'h00000063
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [2:0] {IDLE, WAIT, WRITE, DONE, ERROR} state_t;

    // One extra pointer bit so the value just past the last slot is representable.
    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(MEM_BYTES - 4);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   ptr;
    logic [1:0]        beat_p1;
    logic [23:0]       bytes_p1;
    logic              halt_p1;
    logic              room;

    assign room = (ptr <= LAST_SLOT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = WAIT;
            WAIT:              if (in_valid) state_nxt = room ? WRITE : ERROR;
            WRITE:             if (beat_p1 == 2'd3) state_nxt = halt_p1 ? DONE : WAIT;
            default:           state_nxt = IDLE;
        endcase
    end

    // Status flags are pure state decodes; leaving DONE/ERROR only happens via start or RST,
    // both of which clear them, so they behave as sticky bits.
    assign in_ready = (state == WAIT);
    assign busy     = (state == WAIT) || (state == WRITE);
    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
    assign overflow = (state == ERROR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            ptr        <= '0;
            word_count <= '0;
            beat_p1    <= '0;
            halt_p1    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        ptr        <= {1'b0, base_addr & ~ADDR_W'(3)};
                        word_count <= '0;
                    end
                end
                // stage p0 -> p1: handshake latches the word and issues beat 0
                WAIT: begin
                    if (in_valid && room) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= ptr[ADDR_W-1:0];
                        wr_data  <= in_word[7:0];
                        bytes_p1 <= in_word[31:8];
                        halt_p1  <= (in_word == HALT_WORD);
                        beat_p1  <= 2'd0;
                    end
                end
                // stage p1: remaining beats shift out of the byte register
                WRITE: begin
                    if (beat_p1 == 2'd3) begin
                        wr_en      <= 1'b0;
                        ptr        <= ptr + (ADDR_W + 1)'(4);
                        word_count <= word_count + 1'b1;
                    end else begin
                        beat_p1  <= beat_p1 + 2'd1;
                        wr_addr  <= wr_addr + 1'b1;
                        wr_data  <= bytes_p1[7:0];
                        bytes_p1 <= {8'h00, bytes_p1[23:8]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-vector bench for imem_loader with a byte-memory model fed from the write port.
module tb_imem_loader;

    localparam int ADDR_W = 7;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_word = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy, cpu_hold, done, overflow;
    logic [ADDR_W-1:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]        mem  [128];
    logic [ADDR_W-1:0] alog [256];
    int                wr_total = 0;

    imem_loader dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
        .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            if (wr_total < 256) alog[wr_total] <= wr_addr;
            wr_total <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        @(negedge CLK);
        start = 1'b1;
        base_addr = b;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    // Returns #1 after the handshake edge, i.e. during beat 0.
    task automatic handshake(input logic [31:0] w);
        int n;
        @(negedge CLK);
        in_valid = 1'b1;
        in_word = w;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) check("hs_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        handshake(w);
        repeat (4) @(posedge CLK);
        #1;
    endtask

    logic [31:0] t1_words [8] = '{32'h00400093, 32'h00008133, 32'h0020A123, 32'h0020A183,
                                  32'h00218233, 32'h00800293, 32'h40128333, 32'h00000063};
    logic [31:0] t2_words [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

    initial begin
        int snap;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);

        check("rst_in_ready",  32'(in_ready), 32'd0);
        check("rst_wr_en",     32'(wr_en), 32'd0);
        check("rst_wr_addr",   32'(wr_addr), 32'd0);
        check("rst_wr_data",   32'(wr_data), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_done",      32'(done), 32'd0);
        check("rst_overflow",  32'(overflow), 32'd0);
        check("rst_wcount",    32'(word_count), 32'd0);
        check("rst_cpu_hold",  32'(cpu_hold), 32'd1);

        // T1: full program ending with the halt word
        do_start(7'd0);
        check("t1_busy_wait", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) send_word(t1_words[i]);
        check("t1_done",     32'(done), 32'd1);
        check("t1_wcount",   32'(word_count), 32'd8);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_busy",     32'(busy), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_mem0",  32'(mem[0]),  32'h93);
        check("t1_mem1",  32'(mem[1]),  32'h00);
        check("t1_mem2",  32'(mem[2]),  32'h40);
        check("t1_mem3",  32'(mem[3]),  32'h00);
        check("t1_mem5",  32'(mem[5]),  32'h81);
        check("t1_mem9",  32'(mem[9]),  32'hA1);
        check("t1_mem10", 32'(mem[10]), 32'h20);
        check("t1_mem27", 32'(mem[27]), 32'h40);
        check("t1_mem28", 32'(mem[28]), 32'h63);
        check("t1_mem29", 32'(mem[29]), 32'h00);

        // T2: in_valid held high, in_ready pattern 1,0,0,0,0
        do_reset();
        do_start(7'd0);
        snap = wr_total;
        @(negedge CLK);
        in_valid = 1'b1;
        in_word = t2_words[0];
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t2_ready_%0d", k), 32'(in_ready), (k % 5 == 0) ? 32'd1 : 32'd0);
            if (k % 5 == 1 && k / 5 + 1 < 3) in_word = t2_words[k / 5 + 1];
            if (k == 11) in_valid = 1'b0;
            @(negedge CLK);
        end
        check("t2_beats", 32'(wr_total - snap), 32'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("t2_addr_%0d", i), 32'(alog[snap + i]), 32'(i));
        check("t2_mem6", 32'(mem[6]), 32'h22);
        check("t2_wcount", 32'(word_count), 32'd3);

        // T3: last slot, then overflow
        do_reset();
        do_start(7'd124);
        send_word(32'h00100093);
        check("t3_mem124", 32'(mem[124]), 32'h93);
        check("t3_mem126", 32'(mem[126]), 32'h10);
        check("t3_mem127", 32'(mem[127]), 32'h00);
        snap = wr_total;
        send_word(32'h00200113);
        check("t3_no_write", 32'(wr_total - snap), 32'd0);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_wcount",   32'(word_count), 32'd1);
        check("t3_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t3_busy",     32'(busy), 32'd0);
        check("t3_in_ready", 32'(in_ready), 32'd0);

        // T4: reset during beat 2
        do_reset();
        do_start(7'd0);
        handshake(32'h11223344);
        repeat (2) @(posedge CLK);
        #1;
        check("t4_beat2_addr", 32'(wr_addr), 32'd2);
        check("t4_beat2_data", 32'(wr_data), 32'h22);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        check("t4_wr_en",     32'(wr_en), 32'd0);
        check("t4_busy",      32'(busy), 32'd0);
        check("t4_in_ready",  32'(in_ready), 32'd0);
        check("t4_wcount",    32'(word_count), 32'd0);
        check("t4_done",      32'(done), 32'd0);
        check("t4_cpu_hold",  32'(cpu_hold), 32'd1);
        check("t4_wr_addr",   32'(wr_addr), 32'd0);

        // T5: start during WRITE is ignored; restart from DONE
        do_start(7'd0);
        handshake(32'h01020304);
        start = 1'b1;
        base_addr = 7'h20;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_wcount1",  32'(word_count), 32'd1);
        send_word(32'h00000063);
        check("t5_mem4",   32'(mem[4]), 32'h63);
        check("t5_done",   32'(done), 32'd1);
        check("t5_wcount2", 32'(word_count), 32'd2);
        do_start(7'h40);
        check("t5_restart_wcount", 32'(word_count), 32'd0);
        check("t5_restart_done",   32'(done), 32'd0);
        check("t5_restart_hold",   32'(cpu_hold), 32'd1);
        send_word(32'hAABBCCDD);
        check("t5_mem40", 32'(mem[64]), 32'hDD);
        check("t5_mem43", 32'(mem[67]), 32'hAA);
        check("t5_wcount3", 32'(word_count), 32'd1);

        // T6: unaligned base is forced to a word boundary
        do_reset();
        do_start(7'd3);
        handshake(32'h00000013);
        check("t6_wr_en",   32'(wr_en), 32'd1);
        check("t6_wr_addr", 32'(wr_addr), 32'd0);
        check("t6_wr_data", 32'(wr_data), 32'h13);
        repeat (4) @(posedge CLK);
        #1;
        check("t6_wcount", 32'(word_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
